// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared state encoding and port indices for the memory arbiter
package memory_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/memory_arbiter_rr.sv
// rr_arbiter2: combinational two-requester round-robin pick
module rr_arbiter2
  import memory_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_grant,
  output logic       o_valid
);
  // on a tie the port not granted last wins, otherwise the sole requester
  always_comb begin
    o_valid = |i_req;
    o_grant = &i_req ? (i_last == PORT1 ? PORT0 : PORT1) : i_req[1];
  end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: serialises two requesters onto one memory port with round-robin fairness
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int SETTLE = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_p0_req,
  input  logic [31:0] i_p0_addr,
  input  logic [31:0] i_p0_wdata,
  input  logic        i_p0_rw,
  output logic [31:0] o_p0_rdata,
  output logic        o_p0_ack,
  input  logic        i_p1_req,
  input  logic [31:0] i_p1_addr,
  input  logic [31:0] i_p1_wdata,
  input  logic        i_p1_rw,
  output logic [31:0] o_p1_rdata,
  output logic        o_p1_ack,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_rw,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_pending
);
  localparam int CW = $clog2(SETTLE + 1);
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_win;
  logic          r_last;
  logic          w_grant;
  logic          w_valid;
  rr_arbiter2 u_rr (
    .i_req  ({i_p1_req, i_p0_req}),
    .i_last (r_last),
    .o_grant(w_grant),
    .o_valid(w_valid)
  );
  // grant in IDLE, hold the command until SETTLE quiet cycles, then acknowledge for one cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_win         <= PORT0;
      r_last        <= PORT1;
      o_p0_rdata    <= '0;
      o_p1_rdata    <= '0;
      o_p0_ack      <= 1'b0;
      o_p1_ack      <= 1'b0;
      o_mem_address <= '0;
      o_mem_wdata   <= '0;
      o_mem_rw      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_valid) begin
          r_win         <= w_grant;
          o_mem_address <= w_grant ? i_p1_addr : i_p0_addr;
          o_mem_wdata   <= w_grant ? i_p1_wdata : i_p0_wdata;
          o_mem_rw      <= w_grant ? i_p1_rw : i_p0_rw;
          r_cnt         <= '0;
          r_state       <= BUSY;
        end
        BUSY: if (i_mem_pending) begin
          r_cnt <= '0;
        end else if (r_cnt == CW'(SETTLE - 1)) begin
          if (!o_mem_rw && r_win) o_p1_rdata <= i_mem_rdata;
          if (!o_mem_rw && !r_win) o_p0_rdata <= i_mem_rdata;
          o_p0_ack <= !r_win;
          o_p1_ack <= r_win;
          o_mem_rw <= 1'b0;
          r_last   <= r_win;
          r_state  <= DONE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        default: begin
          o_p0_ack <= 1'b0;
          o_p1_ack <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: randomized transaction-level check of the memory arbiter
module tb_memory_arbiter;
  localparam int SETTLE = 3;
  logic        clk = 1'b0;
  logic        rst;
  logic        req[2];
  logic [31:0] addr[2];
  logic [31:0] wdata[2];
  logic        rw[2];
  logic [31:0] rdata[2];
  logic        ack[2];
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_rw, mem_pending;
  logic        s_req, s_ack, s_p1_ack, s_mrw, s_pending;
  logic [31:0] s_rdata, s_p1_rdata, s_maddr, s_mwdata, s_mrdata;
  int          total = 0;
  int          bad = 0;
  int          last;
  logic [31:0] exp_rd[2];

  always #5 clk = ~clk;

  memory_arbiter #(.SETTLE(SETTLE)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_p0_req(req[0]), .i_p0_addr(addr[0]), .i_p0_wdata(wdata[0]), .i_p0_rw(rw[0]),
    .o_p0_rdata(rdata[0]), .o_p0_ack(ack[0]),
    .i_p1_req(req[1]), .i_p1_addr(addr[1]), .i_p1_wdata(wdata[1]), .i_p1_rw(rw[1]),
    .o_p1_rdata(rdata[1]), .o_p1_ack(ack[1]),
    .o_mem_address(mem_address), .o_mem_wdata(mem_wdata), .o_mem_rw(mem_rw),
    .i_mem_rdata(mem_rdata), .i_mem_pending(mem_pending)
  );

  memory_arbiter #(.SETTLE(1)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_p0_req(s_req), .i_p0_addr(32'h0000_0100), .i_p0_wdata(32'h0), .i_p0_rw(1'b0),
    .o_p0_rdata(s_rdata), .o_p0_ack(s_ack),
    .i_p1_req(1'b0), .i_p1_addr(32'h0), .i_p1_wdata(32'h0), .i_p1_rw(1'b0),
    .o_p1_rdata(s_p1_rdata), .o_p1_ack(s_p1_ack),
    .o_mem_address(s_maddr), .o_mem_wdata(s_mwdata), .o_mem_rw(s_mrw),
    .i_mem_rdata(s_mrdata), .i_mem_pending(s_pending)
  );

  task automatic rnd_fields;
    for (int i = 0; i < 2; i++) begin
      addr[i]  = $urandom;
      wdata[i] = $urandom;
      rw[i]    = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic txn(input bit q0, input bit q1, input int pstart, input int plen,
                     input bit late, input logic [31:0] md);
    int w, lat;
    req[0] = q0;
    req[1] = q1;
    mem_rdata = md;
    mem_pending = 1'b0;
    w = (q0 && q1) ? (last == 1 ? 0 : 1) : (q0 ? 0 : 1);
    lat = plen > 0 ? pstart + plen - 1 + SETTLE : SETTLE;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c <= lat) begin
        total++;
        if (mem_address !== addr[w] || mem_wdata !== wdata[w] || mem_rw !== rw[w] ||
            ack[0] !== 1'b0 || ack[1] !== 1'b0) begin
          bad++;
          $display("FAIL busy c=%0d: addr=%h wd=%h rw=%b ack=%b%b, want addr=%h wd=%h rw=%b ack=00",
                   c, mem_address, mem_wdata, mem_rw, ack[1], ack[0], addr[w], wdata[w], rw[w]);
        end
      end else begin
        if (!rw[w]) exp_rd[w] = md;
        total++;
        if (ack[w] !== 1'b1 || ack[1-w] !== 1'b0 || mem_rw !== 1'b0) begin
          bad++;
          $display("FAIL ack cycle %0d: ack=%b%b rw=%b, want winner p%0d only, rw=0",
                   c, ack[1], ack[0], mem_rw, w);
        end
        total++;
        if (rdata[0] !== exp_rd[0] || rdata[1] !== exp_rd[1]) begin
          bad++;
          $display("FAIL rdata: p0=%h p1=%h, want p0=%h p1=%h", rdata[0], rdata[1], exp_rd[0], exp_rd[1]);
        end
      end
      mem_pending = (c >= pstart && c < pstart + plen);
    end
    last = w;
    if (!late) req[w] = 1'b0;
    @(negedge clk);
    total++;
    if (ack[0] !== 1'b0 || ack[1] !== 1'b0 || mem_rw !== 1'b0) begin
      bad++;
      $display("FAIL idle: ack=%b%b rw=%b, want ack=00 rw=0", ack[1], ack[0], mem_rw);
    end
    req[w] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = '{1'b0, 1'b0};
    rnd_fields();
    mem_rdata = '0;
    mem_pending = 1'b0;
    s_req = 1'b0;
    s_pending = 1'b0;
    s_mrdata = '0;
    last = 1;
    exp_rd = '{32'h0, 32'h0};
    @(negedge clk);
    @(negedge clk);
    total++;
    if (rdata[0] !== 0 || rdata[1] !== 0 || ack[0] !== 0 || ack[1] !== 0 ||
        mem_address !== 0 || mem_wdata !== 0 || mem_rw !== 0) begin
      bad++;
      $display("FAIL reset: rd=%h/%h ack=%b%b addr=%h wd=%h rw=%b, want all zero",
               rdata[0], rdata[1], ack[1], ack[0], mem_address, mem_wdata, mem_rw);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hit_read;
    addr[0] = 32'h0000_0040;
    rw[0] = 1'b0;
    txn(1, 0, 0, 0, 0, 32'hDEAD_BEEF);
  endtask

  task automatic test_pending_write;
    addr[1] = 32'h0000_0080;
    wdata[1] = 32'h1234_5678;
    rw[1] = 1'b1;
    txn(0, 1, 2, 4, 0, $urandom);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      rnd_fields();
      txn(1, 1, 0, 0, 0, $urandom);
      total++;
      if (last !== i % 2) begin
        bad++;
        $display("FAIL alternate %0d: got p%0d, want p%0d", i, last, i % 2);
      end
    end
  endtask

  task automatic test_reset_mid_busy;
    addr[0] = 32'h0000_0200;
    wdata[0] = 32'hCAFE_F00D;
    rw[0] = 1'b1;
    req[0] = 1'b1;
    req[1] = 1'b0;
    mem_pending = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (mem_rw !== 1'b1) begin
      bad++;
      $display("FAIL pre-reset rw=%b, want 1", mem_rw);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (mem_rw !== 1'b0 || ack[0] !== 1'b0 || rdata[0] !== 0 || rdata[1] !== 0) begin
      bad++;
      $display("FAIL async reset: rw=%b ack0=%b rd=%h/%h, want 0", mem_rw, ack[0], rdata[0], rdata[1]);
    end
    req[0] = 1'b0;
    exp_rd = '{32'h0, 32'h0};
    last = 1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < SETTLE + 3; c++) begin
      @(negedge clk);
      total++;
      if (ack[0] !== 1'b0 || ack[1] !== 1'b0 || mem_rw !== 1'b0) begin
        bad++;
        $display("FAIL post-reset c=%0d ack=%b%b rw=%b, want 0", c, ack[1], ack[0], mem_rw);
      end
    end
    rnd_fields();
    txn(1, 1, 0, 0, 0, $urandom);
    total++;
    if (last !== 0) begin
      bad++;
      $display("FAIL first tie after reset: got p%0d, want p0", last);
    end
  endtask

  task automatic test_drop_after_ack;
    rnd_fields();
    txn(0, 1, 0, 0, 0, $urandom);
    rnd_fields();
    txn(1, 1, 0, 0, 1, $urandom);
    rnd_fields();
    txn(0, 1, 0, 0, 0, $urandom);
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      int q;
      q = $urandom_range(1, 3);
      rnd_fields();
      if ($urandom_range(0, 1) == 1)
        txn(q[0], q[1], $urandom_range(1, SETTLE), $urandom_range(1, 4), $urandom_range(0, 1), $urandom);
      else
        txn(q[0], q[1], 0, 0, $urandom_range(0, 1), $urandom);
    end
  endtask

  task automatic test_settle1;
    s_mrdata = 32'h0BAD_F00D;
    s_req = 1'b1;
    @(negedge clk);
    total++;
    if (s_ack !== 1'b0 || s_maddr !== 32'h0000_0100) begin
      bad++;
      $display("FAIL settle1 c1: ack=%b addr=%h, want 0 and 00000100", s_ack, s_maddr);
    end
    s_req = 1'b0;
    @(negedge clk);
    total++;
    if (s_ack !== 1'b1 || s_rdata !== 32'h0BAD_F00D || s_p1_ack !== 1'b0) begin
      bad++;
      $display("FAIL settle1 c2: ack=%b rd=%h, want 1 and 0badf00d", s_ack, s_rdata);
    end
    @(negedge clk);
    total++;
    if (s_ack !== 1'b0) begin
      bad++;
      $display("FAIL settle1 c3: ack=%b, want 0", s_ack);
    end
  endtask

  initial begin
    test_reset();
    test_hit_read();
    test_pending_write();
    test_back_to_back();
    test_reset_mid_busy();
    test_drop_after_ack();
    test_random();
    test_settle1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
